// File: rtl/reg_dump_pkg.sv
// Shared types and widths for the register dump engine.
// Holds the FSM state encoding and the register file address/data widths.
// Imported by reg_dump and reg_dump_csum.
package reg_dump_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      SEND  = 3'd2,
      TRAIL = 3'd3,
      FIN   = 3'd4
   } state_e;

endpackage

// File: rtl/reg_dump_csum.sv
// Running modulo-2^32 sum of the register beats accepted during a dump.
// Latency: sum_o reflects an add or clear one cycle after it is requested.
// Backpressure: none; the caller only asserts add_i on an accepted beat.
module reg_dump_csum
   import reg_dump_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear_i,
   input  logic                  add_i,
   input  logic [REG_DATA_W-1:0] data_i,
   output logic [REG_DATA_W-1:0] sum_o
);

   logic [REG_DATA_W-1:0] sum_q, sum_d;

   // Clear wins over add so a fresh dump never inherits a stale total.
   always_comb begin
      sum_d = sum_q;
      if (clear_i) begin
         sum_d = '0;
      end else if (add_i) begin
         sum_d = sum_q + data_i;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/reg_dump.sv
// Streams register file contents FIRST_ADDR..LAST_ADDR out as valid/ready beats.
// Latency: one READ cycle per register, so at best one beat every 2 cycles.
// Backpressure: dump_ready low parks the FSM in SEND/TRAIL with payload and RsAddr frozen.
// Optional checksum trailer beat when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump
   import reg_dump_pkg::*;
#(
   parameter logic [REG_ADDR_W-1:0] FIRST_ADDR = 5'd1,
   parameter logic [REG_ADDR_W-1:0] LAST_ADDR  = 5'd31
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [REG_ADDR_W-1:0] RsAddr,
   input  logic [REG_DATA_W-1:0] RsData,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [REG_ADDR_W-1:0] dump_addr,
   output logic [REG_DATA_W-1:0] dump_data,
   output logic                  dump_last,
   output logic                  dump_csum,
   output logic                  busy,
   output logic                  done
);

   state_e                state_q, state_d;
   logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
   logic [REG_ADDR_W-1:0] rs_addr_q, rs_addr_d;
   logic [REG_ADDR_W-1:0] addr_q, addr_d;
   logic [REG_DATA_W-1:0] data_q, data_d;
   logic                  last_q, last_d;

`ifdef REG_DUMP_CHECKSUM_EN
   logic                  csum_q, csum_d;
   logic [REG_DATA_W-1:0] csum_sum;

   reg_dump_csum u_csum (
      .clk     (clk),
      .reset   (reset),
      .clear_i (state_q == IDLE && start),
      .add_i   (state_q == SEND && dump_ready),
      .data_i  (data_q),
      .sum_o   (csum_sum)
   );
`endif

   // Next-state and datapath loads; RsAddr only moves when the counter is loaded.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rs_addr_d = rs_addr_q;
      addr_d    = addr_q;
      data_d    = data_q;
      last_d    = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d     = FIRST_ADDR;
               rs_addr_d = FIRST_ADDR;
               state_d   = READ;
            end
         end
         READ: begin
            addr_d  = cnt_q;
            data_d  = RsData;
`ifdef REG_DUMP_CHECKSUM_EN
            last_d  = 1'b0;
`else
            last_d  = (cnt_q == LAST_ADDR);
`endif
            state_d = SEND;
         end
         SEND: begin
            if (dump_ready) begin
               last_d = 1'b0;
               if (cnt_q < LAST_ADDR) begin
                  cnt_d     = cnt_q + 5'd1;
                  rs_addr_d = cnt_q + 5'd1;
                  state_d   = READ;
               end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                  // Trailer carries the total including the beat just accepted.
                  addr_d  = '0;
                  data_d  = csum_sum + data_q;
                  last_d  = 1'b1;
                  csum_d  = 1'b1;
                  state_d = TRAIL;
`else
                  state_d = FIN;
`endif
               end
            end
         end
         TRAIL: begin
            if (dump_ready) begin
               last_d  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
               csum_d  = 1'b0;
`endif
               state_d = FIN;
            end
         end
         FIN: begin
            // start is deliberately not looked at here.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= FIRST_ADDR;
         rs_addr_q <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         last_q    <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
         csum_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rs_addr_q <= rs_addr_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         last_q    <= last_d;
`ifdef REG_DUMP_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign RsAddr     = rs_addr_q;
   assign dump_addr  = addr_q;
   assign dump_data  = data_q;
   assign dump_last  = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
   assign dump_csum  = csum_q;
`else
   assign dump_csum  = 1'b0;
`endif
   assign dump_valid = (state_q == SEND) || (state_q == TRAIL);
   // busy goes high in the same cycle start is taken.
   assign busy       = (state_q == IDLE && start) || (state_q == READ) ||
                       (state_q == SEND) || (state_q == TRAIL);
   assign done       = (state_q == FIN);

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: full dumps, stalls, reset abort, ignored start, single register.
// A register file model answers RsAddr combinationally; a negedge monitor logs accepted beats.
module tb_reg_dump;

`ifdef REG_DUMP_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif
   localparam int NB = 31 + int'(CSUM_EN);
   localparam logic [31:0] PAT = 32'h55aaaa55;

   int errors = 0;
   int checks = 0;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic dump_ready = 1'b0;
   logic [4:0]  RsAddr, dump_addr;
   logic [31:0] RsData, dump_data;
   logic dump_valid, dump_last, dump_csum, busy, done;

   logic start1 = 1'b0;
   logic ready1 = 1'b0;
   logic [4:0]  rs1, addr1;
   logic [31:0] rd1, data1;
   logic valid1, last1, csum1, busy1, done1;

   logic [31:0] rf [0:31];

   always #5 clk = ~clk;

   assign RsData = rf[RsAddr];
   assign rd1    = rf[rs1];

   reg_dump u_dut (
      .clk(clk), .reset(reset), .start(start), .RsAddr(RsAddr), .RsData(RsData),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
      .dump_data(dump_data), .dump_last(dump_last), .dump_csum(dump_csum),
      .busy(busy), .done(done)
   );

   reg_dump #(.FIRST_ADDR(5'd7), .LAST_ADDR(5'd7)) u_one (
      .clk(clk), .reset(reset), .start(start1), .RsAddr(rs1), .RsData(rd1),
      .dump_valid(valid1), .dump_ready(ready1), .dump_addr(addr1),
      .dump_data(data1), .dump_last(last1), .dump_csum(csum1),
      .busy(busy1), .done(done1)
   );

   // Beat log and protocol monitor
   logic [4:0]  q_addr[$];
   logic [31:0] q_data[$];
   logic        q_last[$];
   logic        q_csum[$];
   int cyc_n = 0, done_cnt = 0, done_cyc = -1, last_hs_cyc = -100, stab_err = 0;
   bit prev_stall = 0;
   logic [4:0]  p_addr, p_rs;
   logic [31:0] p_data;
   logic        p_last, p_csum;

   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 0;
      end else begin
         if (prev_stall && (!dump_valid || dump_addr !== p_addr || dump_data !== p_data ||
                            dump_last !== p_last || dump_csum !== p_csum || RsAddr !== p_rs))
            stab_err++;
         if (dump_valid && dump_ready) begin
            q_addr.push_back(dump_addr);
            q_data.push_back(dump_data);
            q_last.push_back(dump_last);
            q_csum.push_back(dump_csum);
            if (dump_last) last_hs_cyc = cyc_n;
         end
         prev_stall = dump_valid && !dump_ready;
         p_addr = dump_addr; p_data = dump_data; p_last = dump_last;
         p_csum = dump_csum; p_rs = RsAddr;
         if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
         end
      end
      cyc_n++;
   end

   task automatic clear_log();
      q_addr.delete(); q_data.delete(); q_last.delete(); q_csum.delete();
      done_cnt = 0; done_cyc = -1; last_hs_cyc = -100; stab_err = 0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
   endtask

   // Runs until done is seen (returns inside the FIN cycle) or the budget expires.
   task automatic run_dump(input bit toggle, input int pulse_at, output bit timeout);
      timeout = 1'b1;
      for (int n = 0; n < 400; n++) begin
         @(posedge clk); #1;
         start = (n == pulse_at);
         if (toggle) dump_ready = ~dump_ready;
         if (done) begin
            timeout = 1'b0;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #3;
      checks++;
      if ({RsAddr, dump_valid, dump_addr, dump_data, dump_last, dump_csum, busy, done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got addr=%0d v=%b da=%0d dd=%h l=%b c=%b busy=%b done=%b want all 0",
                  RsAddr, dump_valid, dump_addr, dump_data, dump_last, dump_csum, busy, done);
      end
      checks++;
      if ({rs1, valid1, addr1, data1, last1, csum1, busy1, done1} !== '0) begin
         errors++;
         $display("FAIL reset_outputs_one: got nonzero outputs on single-register instance, want all 0");
      end
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || dump_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b valid=%b done=%b want 0 0 0", busy, dump_valid, done);
      end
   endtask

   task automatic test_full_dump();
      bit to;
      logic [31:0] exp_sum;
      logic [4:0]  ea;
      logic [31:0] ed;
      logic        el, ec;
      exp_sum = '0;
      for (int i = 1; i < 32; i++) begin
         rf[i] = PAT;
         exp_sum = exp_sum + PAT;
      end
      clear_log();
      dump_ready = 1'b1;
      @(posedge clk); #1; start = 1'b1; #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_on_start: got %b want 1", busy);
      end
      @(posedge clk); #1; start = 1'b0;
      checks++;
      if (RsAddr !== 5'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL first_read: RsAddr=%0d busy=%b want 1 1", RsAddr, busy);
      end
      run_dump(1'b0, -1, to);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL full_timeout: no done within budget, got 1 want 0");
      end
      checks++;
      if (busy !== 1'b0 || dump_valid !== 1'b0) begin
         errors++;
         $display("FAIL fin_outputs: busy=%b valid=%b want 0 0", busy, dump_valid);
      end
      @(negedge clk); #1;
      checks++;
      if (q_addr.size() != NB) begin
         errors++;
         $display("FAIL full_beat_count: got %0d want %0d", q_addr.size(), NB);
      end
      for (int k = 0; k < NB && k < q_addr.size(); k++) begin
         if (k < 31) begin
            ea = 5'(k + 1); ed = PAT; el = (k == 30) && !CSUM_EN; ec = 1'b0;
         end else begin
            ea = 5'd0; ed = exp_sum; el = 1'b1; ec = 1'b1;
         end
         checks++;
         if (q_addr[k] !== ea || q_data[k] !== ed || q_last[k] !== el || q_csum[k] !== ec) begin
            errors++;
            $display("FAIL full_beat[%0d]: got a=%0d d=%h l=%b c=%b want a=%0d d=%h l=%b c=%b",
                     k, q_addr[k], q_data[k], q_last[k], q_csum[k], ea, ed, el, ec);
         end
      end
      checks++;
      if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
         errors++;
         $display("FAIL full_done: got count=%0d at cyc %0d want 1 at cyc %0d",
                  done_cnt, done_cyc, last_hs_cyc + 1);
      end
   endtask

   task automatic test_backpressure();
      bit to;
      logic [31:0] exp_sum;
      logic [4:0]  ea;
      logic [31:0] ed;
      logic        el, ec;
      exp_sum = '0;
      for (int i = 1; i < 32; i++) begin
         rf[i] = 32'(i);
         exp_sum = exp_sum + 32'(i);
      end
      clear_log();
      dump_ready = 1'b1;
      pulse_start();
      run_dump(1'b1, -1, to);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL toggle_timeout: no done within budget, got 1 want 0");
      end
      @(negedge clk); #1;
      checks++;
      if (q_addr.size() != NB) begin
         errors++;
         $display("FAIL toggle_beat_count: got %0d want %0d", q_addr.size(), NB);
      end
      for (int k = 0; k < NB && k < q_addr.size(); k++) begin
         if (k < 31) begin
            ea = 5'(k + 1); ed = 32'(k + 1); el = (k == 30) && !CSUM_EN; ec = 1'b0;
         end else begin
            ea = 5'd0; ed = exp_sum; el = 1'b1; ec = 1'b1;
         end
         checks++;
         if (q_addr[k] !== ea || q_data[k] !== ed || q_last[k] !== el || q_csum[k] !== ec) begin
            errors++;
            $display("FAIL toggle_beat[%0d]: got a=%0d d=%h l=%b c=%b want a=%0d d=%h l=%b c=%b",
                     k, q_addr[k], q_data[k], q_last[k], q_csum[k], ea, ed, el, ec);
         end
      end
      checks++;
      if (stab_err != 0) begin
         errors++;
         $display("FAIL stall_stability: got %0d violations want 0", stab_err);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL toggle_done: got %0d want 1", done_cnt);
      end
   endtask

   task automatic test_reset_mid_dump();
      bit to;
      int n;
      clear_log();
      dump_ready = 1'b1;
      pulse_start();
      n = 0;
      while (q_addr.size() < 5 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (q_addr.size() < 5) begin
         errors++;
         $display("FAIL abort_wait: got %0d beats want 5", q_addr.size());
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({RsAddr, dump_valid, dump_addr, dump_data, dump_last, dump_csum, busy, done} !== '0) begin
         errors++;
         $display("FAIL abort_outputs: got addr=%0d v=%b da=%0d dd=%h l=%b c=%b busy=%b done=%b want all 0",
                  RsAddr, dump_valid, dump_addr, dump_data, dump_last, dump_csum, busy, done);
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done_cnt != 0 || busy !== 1'b0 || dump_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_restart: done_cnt=%0d busy=%b valid=%b want 0 0 0",
                  done_cnt, busy, dump_valid);
      end
      clear_log();
      pulse_start();
      run_dump(1'b0, -1, to);
      @(negedge clk); #1;
      checks++;
      if (to || q_addr.size() != NB || done_cnt != 1) begin
         errors++;
         $display("FAIL restart_dump: got timeout=%b beats=%0d done=%0d want 0 %0d 1",
                  to, q_addr.size(), done_cnt, NB);
      end
      for (int k = 0; k < 31 && k < q_addr.size(); k++) begin
         checks++;
         if (q_addr[k] !== 5'(k + 1)) begin
            errors++;
            $display("FAIL restart_addr[%0d]: got %0d want %0d", k, q_addr[k], k + 1);
         end
      end
   endtask

   task automatic test_start_ignored();
      bit to;
      clear_log();
      dump_ready = 1'b1;
      pulse_start();
      run_dump(1'b0, 10, to);
      // Still in FIN: a start here must be dropped.
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if (to || q_addr.size() != NB || done_cnt != 1) begin
         errors++;
         $display("FAIL start_ignored: got timeout=%b beats=%0d done=%0d want 0 %0d 1",
                  to, q_addr.size(), done_cnt, NB);
      end
      checks++;
      if (busy !== 1'b0 || dump_valid !== 1'b0) begin
         errors++;
         $display("FAIL start_in_fin: busy=%b valid=%b want 0 0", busy, dump_valid);
      end
   endtask

   task automatic test_single_register();
      rf[7] = 32'hDEADBEEF;
      ready1 = 1'b0;
      @(posedge clk); #1; start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      checks++;
      if (rs1 !== 5'd7 || busy1 !== 1'b1) begin
         errors++;
         $display("FAIL single_read: RsAddr=%0d busy=%b want 7 1", rs1, busy1);
      end
      @(posedge clk); #1;
      checks++;
      if (valid1 !== 1'b1 || addr1 !== 5'd7 || data1 !== 32'hDEADBEEF || last1 !== !CSUM_EN) begin
         errors++;
         $display("FAIL single_beat: got v=%b a=%0d d=%h l=%b want 1 7 deadbeef %b",
                  valid1, addr1, data1, last1, !CSUM_EN);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (valid1 !== 1'b1 || addr1 !== 5'd7 || data1 !== 32'hDEADBEEF || rs1 !== 5'd7) begin
         errors++;
         $display("FAIL single_stall: got v=%b a=%0d d=%h rs=%0d want 1 7 deadbeef 7",
                  valid1, addr1, data1, rs1);
      end
      ready1 = 1'b1;
      @(posedge clk); #1;
      if (CSUM_EN) begin
         checks++;
         if (valid1 !== 1'b1 || csum1 !== 1'b1 || last1 !== 1'b1 || addr1 !== 5'd0 ||
             data1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_trailer: got v=%b c=%b l=%b a=%0d d=%h want 1 1 1 0 deadbeef",
                     valid1, csum1, last1, addr1, data1);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (done1 !== 1'b1 || valid1 !== 1'b0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL single_done: got done=%b v=%b busy=%b want 1 0 0", done1, valid1, busy1);
      end
      @(posedge clk); #1;
      checks++;
      if (done1 !== 1'b0) begin
         errors++;
         $display("FAIL single_done_width: got %b want 0", done1);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      test_reset();
      test_full_dump();
      test_backpressure();
      test_reset_mid_dump();
      test_start_ignored();
      test_single_register();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
